inst_rom_arbiter: RTL

Shares the single combinational-read instruction ROM between the CPU fetch port and a debug/loader read port. Fetch has priority; a pending debug read is served opportunistically on any cycle the CPU does not fetch. After `MAX_WAIT` denied cycles, the debug read is forced and the CPU is stalled for one cycle. Sits between `openmips` and `inst_mem` in the SOPC top, replacing the direct ROM connection.

---
 rtl/inst_rom_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/inst_rom_arbiter.sv
// Shares one combinational-read instruction ROM between the CPU fetch port and a
// debug/loader read port. Fetch wins; a debug read waiting MAX_WAIT cycles is forced.
module inst_rom_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    // CPU fetch port
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              stallreq_o,
    // debug/loader read port
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              dbg_valid_o,
    // ROM side
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    // arbiter state for observation: 0 = IDLE, 1 = PEND, 2 = FORCE
    output logic [1:0]        fsm_state_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic              dbg_valid_q, dbg_valid_d;
    logic              gnt_raw;
    logic              gnt;

    // Next-state logic; cnt counts cycles the current debug request was denied.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg_req_i) begin
                    if (!if_ce_i) begin
                        gnt_raw = 1'b1;
                    end else begin
                        cnt_d   = ONE;
                        state_d = (MAX_WAIT == 1) ? FORCE : PEND;
                    end
                end
            end
            PEND: begin
                if (!dbg_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!if_ce_i) begin
                    gnt_raw = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q + ONE == MAX_CNT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                gnt_raw = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Every combinational output is held low while reset is asserted.
    assign gnt = rst & gnt_raw;

    always_comb begin
        rom_ce_o   = 1'b0;
        rom_addr_o = '0;
        if_inst_o  = '0;
        if (rst) begin
            rom_ce_o = if_ce_i | gnt;
            if (gnt) begin
                rom_addr_o = dbg_addr_i;
            end else if (if_ce_i) begin
                rom_addr_o = if_addr_i;
                if_inst_o  = rom_data_i;
            end
        end
    end

    // A forced grant during a fetch hands the CPU a NOP and asks for a stall.
    assign stallreq_o = gnt & if_ce_i;
    assign dbg_ack_o  = gnt;

    always_comb begin
        dbg_valid_d = gnt;
        dbg_data_d  = gnt ? rom_data_i : dbg_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dbg_data_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbg_data_q  <= dbg_data_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end

    assign dbg_data_o  = dbg_data_q;
    assign dbg_valid_o = dbg_valid_q;
    assign fsm_state_o = state_q;

endmodule
